// File: rtl/sat_pkg.sv
// Types and constants shared by the SAT datapath blocks (trace_table, backtrack_unit).
// The trace entry layout must stay identical to the one trace_table stores.
package sat_pkg;

  localparam int SAT_VAR_IDX_MSB = 8;
  localparam int VAR_W           = SAT_VAR_IDX_MSB + 1;

  localparam logic TRACE_DECISION = 1'b0;
  localparam logic TRACE_FORCED   = 1'b1;

  typedef struct packed {
    logic             t_type;
    logic             val;
    logic [VAR_W-1:0] variable;
  } trace_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP_REQ   = 3'd1,
    ST_POP_WAIT  = 3'd2,
    ST_UNASSIGN  = 3'd3,
    ST_FLIP      = 3'd4,
    ST_PUSH_REQ  = 3'd5,
    ST_PUSH_WAIT = 3'd6,
    ST_FINISH    = 3'd7
  } bt_state_t;

endpackage

// File: rtl/backtrack_unit.sv
// Conflict backtrack controller: pops the trace to the latest decision, unassigns forced
// variables on the way, flips the decision and re-pushes it as forced; reports UNSAT on empty.
module backtrack_unit
  import sat_pkg::*;
#(
  parameter  int NUM_VARIABLE     = 128,
  parameter  int VARIABLE_INDEXES = 8,
  localparam int CNT_W            = $clog2(NUM_VARIABLE + 2)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      unsat,
  output logic [CNT_W-1:0]          pop_count,
  output logic                      tt_pop,
  output logic                      tt_push,
  output logic                      tt_type,
  output logic                      tt_val,
  output logic [VARIABLE_INDEXES:0] tt_variable,
  input  logic                      tt_type_in,
  input  logic                      tt_val_in,
  input  logic [VARIABLE_INDEXES:0] tt_variable_in,
  input  logic                      tt_empty,
  input  logic                      tt_done,
  output logic                      va_we,
  output logic [VARIABLE_INDEXES:0] va_variable,
  output logic                      va_assigned,
  output logic                      va_val
);

  bt_state_t                 r_state, w_state_next;
  trace_entry_t              r_entry, w_entry_next;
  logic [CNT_W-1:0]          r_pop_count, w_pop_count_next;
  logic                      r_unsat, w_unsat_next;
  logic                      r_busy, r_done, r_tt_pop, r_tt_push, r_tt_type, r_tt_val;
  logic                      w_busy, w_done, w_tt_pop, w_tt_push, w_tt_type, w_tt_val;
  logic [VARIABLE_INDEXES:0] r_tt_variable, w_tt_variable;
  logic                      r_va_we, r_va_assigned, r_va_val;
  logic                      w_va_we, w_va_assigned, w_va_val;
  logic [VARIABLE_INDEXES:0] r_va_variable, w_va_variable;

  // Next state plus next output values; outputs are computed one cycle ahead so they register cleanly.
  always_comb begin
    w_state_next     = r_state;
    w_entry_next     = r_entry;
    w_pop_count_next = r_pop_count;
    w_unsat_next     = r_unsat;
    w_done           = 1'b0;
    w_tt_pop         = 1'b0;
    w_tt_push        = 1'b0;
    w_tt_type        = 1'b0;
    w_tt_val         = 1'b0;
    w_tt_variable    = '0;
    w_va_we          = 1'b0;
    w_va_variable    = '0;
    w_va_assigned    = 1'b0;
    w_va_val         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next     = ST_POP_REQ;
          w_pop_count_next = '0;
          w_unsat_next     = 1'b0;
          w_tt_pop         = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_POP_REQ: w_state_next = ST_POP_WAIT;
      ST_POP_WAIT: begin
        if (tt_done && tt_empty) begin
          w_state_next = ST_FINISH;
          w_unsat_next = 1'b1;
          w_done       = 1'b1;
        end else if (tt_done) begin
          w_entry_next = '{t_type: tt_type_in, val: tt_val_in, variable: tt_variable_in};
          if (r_pop_count != {CNT_W{1'b1}}) begin
            w_pop_count_next = r_pop_count + CNT_W'(1);
          end else begin
            w_pop_count_next = r_pop_count;
          end
          w_va_we       = 1'b1;
          w_va_variable = tt_variable_in;
          if (tt_type_in == TRACE_FORCED) begin
            w_state_next = ST_UNASSIGN;
          end else begin
            w_state_next  = ST_FLIP;
            w_va_assigned = 1'b1;
            w_va_val      = ~tt_val_in;
          end
        end else begin
          w_state_next = ST_POP_WAIT;
        end
      end
      ST_UNASSIGN: begin
        w_state_next = ST_POP_REQ;
        w_tt_pop     = 1'b1;
      end
      ST_FLIP: begin
        w_state_next  = ST_PUSH_REQ;
        w_tt_push     = 1'b1;
        w_tt_type     = TRACE_FORCED;
        w_tt_val      = ~r_entry.val;
        w_tt_variable = r_entry.variable;
      end
      ST_PUSH_REQ: begin
        w_state_next  = ST_PUSH_WAIT;
        w_tt_type     = r_tt_type;
        w_tt_val      = r_tt_val;
        w_tt_variable = r_tt_variable;
      end
      ST_PUSH_WAIT: begin
        // Pushed fields stay stable until trace_table acknowledges.
        if (tt_done) begin
          w_state_next = ST_FINISH;
          w_done       = 1'b1;
        end else begin
          w_state_next  = ST_PUSH_WAIT;
          w_tt_type     = r_tt_type;
          w_tt_val      = r_tt_val;
          w_tt_variable = r_tt_variable;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    w_busy = (w_state_next != ST_IDLE);
  end

  // State, capture register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_entry       <= '0;
      r_pop_count   <= '0;
      r_unsat       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tt_pop      <= 1'b0;
      r_tt_push     <= 1'b0;
      r_tt_type     <= 1'b0;
      r_tt_val      <= 1'b0;
      r_tt_variable <= '0;
      r_va_we       <= 1'b0;
      r_va_variable <= '0;
      r_va_assigned <= 1'b0;
      r_va_val      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_entry       <= w_entry_next;
      r_pop_count   <= w_pop_count_next;
      r_unsat       <= w_unsat_next;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_tt_pop      <= w_tt_pop;
      r_tt_push     <= w_tt_push;
      r_tt_type     <= w_tt_type;
      r_tt_val      <= w_tt_val;
      r_tt_variable <= w_tt_variable;
      r_va_we       <= w_va_we;
      r_va_variable <= w_va_variable;
      r_va_assigned <= w_va_assigned;
      r_va_val      <= w_va_val;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign unsat       = r_unsat;
  assign pop_count   = r_pop_count;
  assign tt_pop      = r_tt_pop;
  assign tt_push     = r_tt_push;
  assign tt_type     = r_tt_type;
  assign tt_val      = r_tt_val;
  assign tt_variable = r_tt_variable;
  assign va_we       = r_va_we;
  assign va_variable = r_va_variable;
  assign va_assigned = r_va_assigned;
  assign va_val      = r_va_val;

endmodule

// File: tb/tb_backtrack_unit.sv
// Randomized scoreboard bench for backtrack_unit with a behavioural trace_table stack model.
module tb_backtrack_unit;
  import sat_pkg::*;

  localparam int VW = 9;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, unsat, tt_pop, tt_push, tt_type, tt_val;
  logic [CW-1:0] pop_count;
  logic [VW-1:0] tt_variable, va_variable;
  logic          tt_type_in = 1'b0, tt_val_in = 1'b0, tt_empty = 1'b0, tt_done = 1'b0;
  logic [VW-1:0] tt_variable_in = '0;
  logic          va_we, va_assigned, va_val;

  typedef struct {
    int            kind;      // 0 = va write, 1 = push, 2 = done
    logic [VW-1:0] var_idx;
    logic          assigned;
    logic          val;
    logic          unsat;
    int            pcount;
    int            cycles;
  } exp_t;

  exp_t         exp_q[$];
  trace_entry_t stack[$];
  trace_entry_t ref_stack[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, lp = 2, lu = 3, n_done = 0, n_accepted = 0;
  bit quiet_window = 1'b0;

  backtrack_unit dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .unsat(unsat),
    .pop_count(pop_count), .tt_pop(tt_pop), .tt_push(tt_push), .tt_type(tt_type),
    .tt_val(tt_val), .tt_variable(tt_variable), .tt_type_in(tt_type_in),
    .tt_val_in(tt_val_in), .tt_variable_in(tt_variable_in), .tt_empty(tt_empty),
    .tt_done(tt_done), .va_we(va_we), .va_variable(va_variable),
    .va_assigned(va_assigned), .va_val(va_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: walk a copy of the stack from the top using the backtrack rules.
  task automatic issue_backtrack();
    trace_entry_t st[$];
    trace_entry_t t;
    exp_t e;
    int  k;
    int  cycles;
    bit  found;
    st = stack; k = 0; cycles = 1; found = 1'b0;
    while (st.size() > 0 && !found) begin
      t = st.pop_back();
      k++;
      cycles += 2 + lp;
      e.kind = 0; e.var_idx = t.variable; e.unsat = 1'b0; e.pcount = 0; e.cycles = 0;
      if (t.t_type == TRACE_FORCED) begin
        e.assigned = 1'b0; e.val = 1'b0;
        exp_q.push_back(e);
      end else begin
        found = 1'b1;
        e.assigned = 1'b1; e.val = ~t.val;
        exp_q.push_back(e);
        e.kind = 1;
        exp_q.push_back(e);
        t.t_type = TRACE_FORCED; t.val = ~t.val;
        st.push_back(t);
        cycles += 1 + lu;
      end
    end
    if (!found) cycles += 1 + lp;
    cycles += 1;
    e.kind = 2; e.var_idx = '0; e.assigned = 1'b0; e.val = 1'b0;
    e.unsat = !found; e.pcount = k; e.cycles = cycles;
    exp_q.push_back(e);
    ref_stack = st;
  endtask

  task automatic run_bt(input bit extra_start);
    int target;
    int waited;
    issue_backtrack();
    target = n_done + 1;
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc; n_accepted++;
    @(posedge clk); #1;
    start = 1'b0;
    if (extra_start) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    waited = 0;
    while (n_done < target && waited < 3000) begin
      @(posedge clk); #2;
      waited++;
    end
    check(n_done >= target, "done_timeout", n_done, target);
    repeat (3) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "missing_events", exp_q.size(), 0);
    exp_q.delete();
    check(stack.size() == ref_stack.size(), "stack_depth", stack.size(), ref_stack.size());
    for (int i = 0; i < stack.size() && i < ref_stack.size(); i++)
      check(stack[i] == ref_stack[i], "stack_entry", int'(stack[i]), int'(ref_stack[i]));
  endtask

  function automatic trace_entry_t mk(input logic ty, input logic v, input int x);
    trace_entry_t t;
    t.t_type = ty; t.val = v; t.variable = VW'(x);
    return t;
  endfunction

  // trace_table stand-in: serves pops/pushes from the stack queue after lp/lu cycles.
  initial begin
    trace_entry_t t;
    logic          h_type, h_val;
    logic [VW-1:0] h_var;
    forever begin
      @(posedge clk); #1;
      if (tt_pop) begin
        repeat (lp) begin @(posedge clk); #1; end
        if (stack.size() == 0) begin
          tt_empty = 1'b1;
        end else begin
          t = stack.pop_back();
          tt_type_in = t.t_type; tt_val_in = t.val; tt_variable_in = t.variable;
        end
        tt_done = 1'b1;
        @(posedge clk); #1;
        tt_done = 1'b0; tt_empty = 1'b0;
      end else if (tt_push) begin
        h_type = tt_type; h_val = tt_val; h_var = tt_variable;
        repeat (lu) begin @(posedge clk); #1; end
        check(tt_type == h_type && tt_val == h_val && tt_variable == h_var, "push_hold",
              int'({tt_type, tt_val, tt_variable}), int'({h_type, h_val, h_var}));
        t.t_type = tt_type; t.val = tt_val; t.variable = tt_variable;
        stack.push_back(t);
        tt_done = 1'b1;
        @(posedge clk); #1;
        tt_done = 1'b0;
      end
    end
  end

  // Monitor: protocol rules every cycle, and scoreboard comparison on each DUT event.
  initial begin
    exp_t e;
    bit   prev_pop, prev_push, prev_done;
    prev_pop = 1'b0; prev_push = 1'b0; prev_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      check(!(tt_pop && tt_push), "pop_push_exclusive", int'({tt_pop, tt_push}), 0);
      check(!(tt_pop && prev_pop) && !(tt_push && prev_push) && !(done && prev_done),
            "single_cycle_pulse", int'({tt_pop, tt_push, done}), 0);
      if (quiet_window)
        check(!(tt_pop || tt_push || va_we || done || busy), "quiet_after_reset",
              int'({tt_pop, tt_push, va_we, done, busy}), 0);
      if (va_we) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_va_we", int'(va_variable), -1);
        else begin
          e = exp_q.pop_front();
          check(e.kind == 0, "va_we_order", 0, e.kind);
          check(va_variable == e.var_idx && va_assigned == e.assigned &&
                (!e.assigned || va_val == e.val), "va_write",
                int'({va_assigned, va_val, va_variable}), int'({e.assigned, e.val, e.var_idx}));
        end
      end
      if (tt_push) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_push", int'(tt_variable), -1);
        else begin
          e = exp_q.pop_front();
          check(e.kind == 1, "push_order", 1, e.kind);
          check(tt_type == TRACE_FORCED && tt_val == e.val && tt_variable == e.var_idx, "push_entry",
                int'({tt_type, tt_val, tt_variable}), int'({TRACE_FORCED, e.val, e.var_idx}));
        end
      end
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) check(1'b0, "unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check(e.kind == 2, "done_order", 2, e.kind);
          check(unsat == e.unsat, "unsat", int'(unsat), int'(e.unsat));
          check(int'(pop_count) == e.pcount, "pop_count", int'(pop_count), e.pcount);
          check(cyc - start_cyc + 1 == e.cycles, "latency", cyc - start_cyc + 1, e.cycles);
          check(busy == 1'b1, "busy_at_done", int'(busy), 1);
        end
      end
      prev_pop = tt_pop; prev_push = tt_push; prev_done = done;
    end
  end

  initial begin
    int depth;
    repeat (3) @(posedge clk);
    #1;
    check({busy, done, unsat, pop_count, tt_pop, tt_push, tt_type, tt_val, tt_variable,
           va_we, va_variable, va_assigned, va_val} == '0, "reset_outputs",
          int'({busy, done, unsat, pop_count, tt_pop, tt_push, va_we}), 0);
    reset = 1'b0;

    stack.delete(); stack.push_back(mk(TRACE_DECISION, 1'b1, 5));
    run_bt(1'b0);
    stack.delete();
    stack.push_back(mk(TRACE_DECISION, 1'b0, 3));
    stack.push_back(mk(TRACE_FORCED, 1'b1, 7));
    stack.push_back(mk(TRACE_FORCED, 1'b0, 9));
    run_bt(1'b1);
    stack.delete();
    run_bt(1'b0);
    check(busy == 1'b0, "idle_after_done", int'(busy), 0);
    stack.push_back(mk(TRACE_FORCED, 1'b1, 2));
    stack.push_back(mk(TRACE_FORCED, 1'b0, 4));
    run_bt(1'b0);
    check(unsat == 1'b1, "unsat_level_held", int'(unsat), 1);

    for (int n = 0; n < 40; n++) begin
      lp = int'($urandom_range(1, 4));
      lu = int'($urandom_range(1, 4));
      stack.delete();
      depth = int'($urandom_range(0, 6));
      for (int d = 0; d < depth; d++)
        stack.push_back(mk(($urandom_range(0, 2) != 0) ? TRACE_FORCED : TRACE_DECISION,
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 511))));
      run_bt(n[2:0] == 3'd5);
    end

    // Reset while waiting for a pop: the sequence is abandoned and the block goes quiet.
    lp = 8;
    stack.delete(); stack.push_back(mk(TRACE_DECISION, 1'b0, 1));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({busy, done, unsat, pop_count, tt_pop, tt_push, tt_type, tt_val, tt_variable,
           va_we, va_variable, va_assigned, va_val} == '0, "reset_mid_op_outputs",
          int'({busy, done, unsat, pop_count, tt_pop, tt_push, va_we}), 0);
    reset = 1'b0;
    quiet_window = 1'b1;
    repeat (20) @(posedge clk);
    #2 quiet_window = 1'b0;

    lp = 1; lu = 1;
    stack.delete(); stack.push_back(mk(TRACE_DECISION, 1'b1, 300));
    run_bt(1'b0);
    check(n_done == n_accepted, "done_per_start", n_done, n_accepted);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
